pipe_ctrl: RTL
==============

# pipe_ctrl

Central stall/flush controller for the 5-stage 16-bit pipeline. Every cycle it decides the write enables of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the flush (NOP-inject) requests for IF/ID and ID/EX. Its inputs are the load-use hazard, EX-stage branch/jump redirect, instruction/data memory busy and HALT retirement. It also keeps saturating stall and flush performance counters. It sits beside the datapath in the top-level processor and owns no data, only control.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  3  source register A of instruction in ID.
- id_rt  in  3  source register B of instruction in ID.
- id_rs_used  in  1  ID instruction reads id_rs.
- id_rt_used  in  1  ID instruction reads id_rt.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  3  destination register of instruction in EX.
- ex_redirect  in  1  branch taken / jump resolved in EX; PC mux selects target.
- imem_busy  in  1  instruction memory cannot deliver this cycle.
- dmem_busy  in  1  data memory access in MEM not complete this cycle.
- wb_halt  in  1  HALT instruction is in WB this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register write enables.
- ifid_flush  out  1  drives IF/ID rst (loads NOP opcode 5'b00001, clears PCs).
- idex_flush  out  1  loads ID/EX with bubble (all control zero).
- halted  out  1  processor stopped.
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted, saturating.
- flush_cnt  out  CNT_W  redirects taken, saturating.

## Operation
- FSM states: RUN, DWAIT, HALT. Reset -> RUN.
- Load-use hazard lu = ex_memread & ex_rd!=0-agnostic match: (id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd). Register r0 is not special.
- Per-cycle priority (highest first):
  - HALT: all enables 0, flushes 0. Exit only by rst.
  - dmem_busy: whole pipe frozen, all enables 0, flushes 0. State -> DWAIT. Stays in DWAIT while dmem_busy, then returns to RUN. Any redirect or lu is re-evaluated after release, because inputs are held by frozen registers.
  - ex_redirect: all enables 1, ifid_flush=1, idex_flush=1. lu and imem_busy are ignored this cycle; the fetch unit aborts on pc_en. flush_cnt +1.
  - lu: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. This is exactly one bubble, since the next cycle's ex_memread=0.
  - imem_busy: pc_en=0, ifid_en=1 with ifid_flush=1 (NOP enters ID), downstream enables 1.
  - otherwise: all enables 1, flushes 0.
- wb_halt in RUN, when not frozen by dmem_busy: halted goes 1 next cycle, and state -> HALT. The HALT instruction itself retires.
- Counters saturate at all-ones and never wrap. stall_cnt increments on any cycle with pc_en=0 and state!=HALT, including the cycle where wb_halt is first seen if pc_en=0.

## Timing
- Enables and flushes are combinational (Mealy) from current state and inputs, so they act on the same edge. The only registered elements are state, halted and the counters.
- Reset values: state RUN, halted 0, stall_cnt 0, flush_cnt 0. During the rst cycle outputs are forced: all enables 1, ifid_flush=1, idex_flush=1, so that pipeline registers clear.
- Load-use costs 1 cycle. A redirect costs 2 flushed slots. A dmem stall of N busy cycles freezes exactly N cycles.
- rst mid-DWAIT or in HALT returns to RUN on the next edge; counters clear.

## Structure
- Package pipe_ctrl_pkg: state enum (RUN, DWAIT, HALT), NOP opcode constant 5'b00001, register-index width 3.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, q), instantiated twice.
- Hazard compare stays inline.

## Test plan
- Reset: hold rst 2 cycles -> enables 1, both flushes 1. After release, halted=0, stall_cnt=0, flush_cnt=0, state RUN.
- Load-use: ex_memread=1, ex_rd=3, id_rs=3, id_rs_used=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. Next cycle (ex_memread=0) -> all enables 1. stall_cnt=1.
- Redirect with concurrent lu and imem_busy -> all enables 1, ifid_flush=idex_flush=1, flush_cnt=1, stall_cnt unchanged.
- dmem_busy high 4 cycles while ex_redirect=1 -> 4 cycles all enables 0, no flush. Then 1 redirect cycle. stall_cnt=4, flush_cnt=1.
- wb_halt pulse -> halted=1 next cycle. Later ex_redirect/lu are ignored, all enables stay 0, counters frozen. rst -> resume RUN.
- Saturation with CNT_W=4: imem_busy held 20 cycles -> stall_cnt stops at 15. Each of those cycles shows ifid_flush=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Imported by the controller top and its counter sub-module.
package pipe_ctrl_pkg;

  localparam int REG_W = 3;

  // Opcode the IF/ID register loads on flush so that ID decodes a NOP.
  localparam logic [4:0] NOP_OPCODE = 5'b00001;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Synchronous active-high reset clears it to zero.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: Mealy enables and flushes
// from a RUN/DWAIT/HALT FSM, plus saturating stall and flush counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  state_t state_q;
  state_t state_d;
  logic   lu;
  logic   halt_take;
  logic   stall_inc;
  logic   flush_inc;

  // r0 is deliberately not excluded: the register file does not hard-wire it.
  assign lu = ex_memread &
              ((id_rs_used & (id_rs == ex_rd)) |
               (id_rt_used & (id_rt == ex_rd)));

  assign state = state_q;

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_d    = state_q;
    halt_take  = 1'b0;
    flush_inc  = 1'b0;

    if (rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state_q == ST_HALT) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (dmem_busy) begin
      // Full freeze: held registers keep every hazard input for re-evaluation.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = ST_DWAIT;
    end else begin
      state_d = ST_RUN;
      if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (lu) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (imem_busy) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      if (wb_halt) begin
        state_d   = ST_HALT;
        halt_take = 1'b1;
      end
    end
  end

  assign stall_inc = !rst && (state_q != ST_HALT) && !pc_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (halt_take) begin
        halted <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .q   (flush_cnt)
  );

endmodule
